// File: rtl/pipe_stall_ctrl.sv
// Hazard/stall controller for a 5-stage MIPS pipeline: Tuse/Tnew dependency stalls plus a
// mult/div busy sequencer. Optional stalled-cycle counter enabled by `define STALL_STAT_EN.
module pipe_stall_ctrl #(
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  D_rs_addr,
  input  logic [4:0]  D_rt_addr,
  input  logic [1:0]  D_tuse_rs,
  input  logic [1:0]  D_tuse_rt,
  input  logic        D_is_md,
  input  logic [4:0]  E_wa,
  input  logic [1:0]  E_tnew,
  input  logic [4:0]  M_wa,
  input  logic [1:0]  M_tnew,
  input  logic        E_md_start,
  input  logic        E_md_div,
  output logic        D_stall,
  output logic        E_flush,
  output logic        md_busy,
  output logic [3:0]  md_count
`ifdef STALL_STAT_EN
  ,
  input  logic        stat_clr,
  output logic [31:0] stall_cnt
`endif
);

  localparam logic [3:0] MultLat = 4'(MULT_LAT);
  localparam logic [3:0] DivLat  = 4'(DIV_LAT);

  typedef enum logic [0:0] {StIdle, StBusy} md_state_e;

  md_state_e  state_q, state_d;
  logic [3:0] count_q, count_d;
  logic       stall_rs, stall_rt, stall_md;

  // Register 0 is hardwired, so a match on it is never a real dependency.
  always_comb begin
    stall_rs = (D_rs_addr != 5'd0) &&
               (((D_rs_addr == E_wa) && (D_tuse_rs < E_tnew)) ||
                ((D_rs_addr == M_wa) && (D_tuse_rs < M_tnew)));
    stall_rt = (D_rt_addr != 5'd0) &&
               (((D_rt_addr == E_wa) && (D_tuse_rt < E_tnew)) ||
                ((D_rt_addr == M_wa) && (D_tuse_rt < M_tnew)));
    stall_md = D_is_md && (md_busy || E_md_start);
    D_stall  = stall_rs || stall_rt || stall_md;
    E_flush  = D_stall;
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    unique case (state_q)
      StIdle: begin
        if (E_md_start) begin
          state_d = StBusy;
          count_d = E_md_div ? DivLat : MultLat;
        end
      end
      StBusy: begin
        // A start while busy is ignored; the md stall keeps it from happening.
        count_d = count_q - 4'd1;
        if (count_q == 4'd1) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        count_d = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      count_q <= 4'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign md_busy  = (state_q == StBusy);
  assign md_count = count_q;

`ifdef STALL_STAT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= 32'd0;
    end else if (stat_clr) begin
      stall_cnt_q <= 32'd0;
    end else if (D_stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
